// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, mux select values
// and the latency/loss counter width.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic SEL_IF  = 1'b0;
    localparam logic SEL_MEM = 1'b1;
    localparam int   NB_CNT  = 4;
endpackage

// File: rtl/arb_lat_counter.sv
// Down-counter tracking the remaining memory latency; o_last flags the final
// wait cycle so the sequencer can step to DONE.
module arb_lat_counter
    import mem_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [NB_CNT-1:0] i_load_val,
    input  logic              i_en,
    output logic              o_last
);
    logic [NB_CNT-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            cnt <= '0;
        else if (i_load)
            cnt <= i_load_val;
        else if (i_en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign o_last = (cnt == NB_CNT'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between IF and MEM, sequences the fixed latency
// and returns a completion strobe. ARB_STARVE_GUARD_EN enables the IF anti-starvation override.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NB_ADDR  = 32,
    parameter int NB_DATA  = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_if_req,
    input  logic [NB_ADDR-1:0] i_if_addr,
    output logic               o_if_gnt,
    output logic               o_if_valid,
    output logic [NB_DATA-1:0] o_if_rdata,
    input  logic               i_mem_req,
    input  logic               i_mem_we,
    input  logic [NB_ADDR-1:0] i_mem_addr,
    input  logic [NB_DATA-1:0] i_mem_wdata,
    output logic               o_mem_gnt,
    output logic               o_mem_valid,
    output logic [NB_DATA-1:0] o_mem_rdata,
    output logic               o_mux_sel,
    output logic               o_port_en,
    output logic               o_port_we,
    output logic [NB_ADDR-1:0] o_port_addr,
    output logic [NB_DATA-1:0] o_port_wdata,
    input  logic [NB_DATA-1:0] i_port_rdata,
    output logic               o_busy
);
    state_t             state, next_state;
    logic               sel_q;
    logic               we_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_DATA-1:0] wdata_q;
    logic               any_req, both_req, sel_mem, force_if, arb_fire, lat_last;

    assign any_req  = i_if_req | i_mem_req;
    assign both_req = i_if_req & i_mem_req;
    assign arb_fire = (state == IDLE) && any_req;
    assign sel_mem  = i_mem_req & ~(i_if_req & force_if);

`ifdef ARB_STARVE_GUARD_EN
    logic [NB_CNT-1:0] if_loss_cnt;

    assign force_if = (if_loss_cnt >= NB_CNT'(MAX_WAIT));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            if_loss_cnt <= '0;
        else if (arb_fire) begin
            if (both_req && sel_mem) begin
                if (if_loss_cnt < NB_CNT'(MAX_WAIT))
                    if_loss_cnt <= if_loss_cnt + 1'b1;
            end else if (!sel_mem)
                if_loss_cnt <= '0;
        end
    end
`else
    // Strict MEM priority; MAX_WAIT has no effect in this build.
    logic unused_both;
    assign unused_both = both_req;
    assign force_if    = 1'b0 & (MAX_WAIT == 0);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sel_q   <= SEL_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (arb_fire) begin
            sel_q   <= sel_mem ? SEL_MEM : SEL_IF;
            we_q    <= sel_mem & i_mem_we;
            addr_q  <= sel_mem ? i_mem_addr : i_if_addr;
            wdata_q <= sel_mem ? i_mem_wdata : '0;
        end
    end

    arb_lat_counter u_lat (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (arb_fire),
        .i_load_val (NB_CNT'(MEM_LAT - 1)),
        .i_en       (state == WAIT),
        .o_last     (lat_last)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = (MEM_LAT > 1) ? WAIT : DONE;
            WAIT:    if (lat_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake strobes decode straight from state; read data is a pass-through.
    always_comb begin
        o_port_en   = (state == ISSUE);
        o_if_gnt    = o_port_en && (sel_q == SEL_IF);
        o_mem_gnt   = o_port_en && (sel_q == SEL_MEM);
        o_port_we   = o_port_en && we_q;
        o_if_valid  = (state == DONE) && (sel_q == SEL_IF);
        o_mem_valid = (state == DONE) && (sel_q == SEL_MEM);
        o_if_rdata  = o_if_valid ? i_port_rdata : '0;
        o_mem_rdata = (o_mem_valid && !we_q) ? i_port_rdata : '0;
    end

    assign o_mux_sel    = sel_q;
    assign o_port_addr  = addr_q;
    assign o_port_wdata = wdata_q;
    assign o_busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected transactions,
// a monitor checks grants, port signals, latency and completions against a memory model.
module tb_mem_port_arbiter;
    localparam int NB_ADDR  = 32;
    localparam int NB_DATA  = 32;
    localparam int MEM_LAT  = 2;
    localparam int MAX_WAIT = 2;
    localparam int TMO      = 300;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic               i_clk = 1'b0, i_reset = 1'b1;
    logic               i_if_req = 1'b0, i_mem_req = 1'b0, i_mem_we = 1'b0;
    logic [NB_ADDR-1:0] i_if_addr = '0, i_mem_addr = '0;
    logic [NB_DATA-1:0] i_mem_wdata = '0, i_port_rdata = '0;
    logic               o_if_gnt, o_if_valid, o_mem_gnt, o_mem_valid;
    logic               o_mux_sel, o_port_en, o_port_we, o_busy;
    logic [NB_DATA-1:0] o_if_rdata, o_mem_rdata, o_port_wdata;
    logic [NB_ADDR-1:0] o_port_addr;

    mem_port_arbiter #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
        .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .o_mem_gnt(o_mem_gnt), .o_mem_valid(o_mem_valid),
        .o_mem_rdata(o_mem_rdata), .o_mux_sel(o_mux_sel), .o_port_en(o_port_en),
        .o_port_we(o_port_we), .o_port_addr(o_port_addr), .o_port_wdata(o_port_wdata),
        .i_port_rdata(i_port_rdata), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic is_mem; logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { logic is_mem; logic we; logic [31:0] addr; logic [31:0] rdata; int cyc; } cmp_t;

    req_t        if_q[$], mem_q[$];
    cmp_t        cmp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic        glog[$];
    logic [1:0]  samp = 2'b00;
    int          cyc = 0, loss = 0, last_gnt = -1;
    int          checks = 0, errors = 0;
    bit          cont_mode = 1'b0;

    always @(posedge i_clk) begin
        cyc  <= cyc + 1;
        samp <= {i_if_req, i_mem_req};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Reference: at each grant, decide the rightful winner from the requests
    // seen at the preceding edge and the running loss count.
    task automatic mon_step();
        logic gi, gm, exp_mem, both;
        req_t e;
        cmp_t c;
        gi = o_if_gnt;
        gm = o_mem_gnt;
        chk("port_en", 64'(o_port_en), 64'(gi | gm));
        if (gi | gm) begin
            chk("single_gnt", 64'(gi & gm), 64'(0));
            both    = samp[1] & samp[0];
            exp_mem = samp[0] && !(both && GUARD && loss >= MAX_WAIT);
            chk("gnt_winner_mem", 64'(gm), 64'(exp_mem));
            chk("mux_sel", 64'(o_mux_sel), 64'(gm));
            if (both && exp_mem) loss = (loss < MAX_WAIT) ? loss + 1 : MAX_WAIT;
            else if (!exp_mem) loss = 0;
            if (cont_mode) begin
                if (last_gnt >= 0) chk("throughput", 64'(cyc - last_gnt), 64'(MEM_LAT + 2));
                last_gnt = cyc;
                glog.push_back(gm);
            end
            if ((gm ? mem_q.size() : if_q.size()) == 0) begin
                checks++; errors++;
                $display("FAIL gnt_unexpected: got grant mem=%0b, required no grant", gm);
            end else begin
                e = gm ? mem_q.pop_front() : if_q.pop_front();
                chk("port_addr", 64'(o_port_addr), 64'(e.addr));
                chk("port_we", 64'(o_port_we), 64'(e.we));
                if (e.we) begin
                    chk("port_wdata", 64'(o_port_wdata), 64'(e.wdata));
                    ref_mem[e.addr] = e.wdata;
                end
                c.is_mem = gm; c.we = e.we; c.addr = e.addr; c.cyc = cyc;
                c.rdata  = e.we ? 32'h0 : rd(e.addr);
                cmp_q.push_back(c);
            end
        end
        chk("busy", 64'(o_busy), 64'(cmp_q.size() != 0));
        if (o_if_valid | o_mem_valid) begin
            if (cmp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL valid_unexpected: got valid if=%0b mem=%0b, required none", o_if_valid, o_mem_valid);
            end else begin
                c = cmp_q.pop_front();
                chk("valid_who_mem", 64'(o_mem_valid), 64'(c.is_mem));
                chk("valid_latency", 64'(cyc - c.cyc), 64'(MEM_LAT));
                chk("rdata", 64'(c.is_mem ? o_mem_rdata : o_if_rdata), 64'(c.rdata));
            end
        end else if (cmp_q.size() != 0 && cyc - cmp_q[0].cyc >= MEM_LAT) begin
            checks++; errors++;
            $display("FAIL valid_missing: got no valid %0d cycles after issue, required valid", cyc - cmp_q[0].cyc);
            void'(cmp_q.pop_front());
        end
        // Present read data only in the cycle the memory would return it.
        if (cmp_q.size() != 0 && cmp_q[0].cyc + MEM_LAT == cyc + 1 && !cmp_q[0].we)
            i_port_rdata = cmp_q[0].rdata;
        else
            i_port_rdata = $urandom;
    endtask

    initial begin : monitor
        forever begin
            @(negedge i_clk);
            if (!i_reset) mon_step();
        end
    end

    task automatic if_access(input logic [31:0] a, output int w);
        req_t e;
        e.is_mem = 1'b0; e.we = 1'b0; e.addr = a; e.wdata = '0;
        if_q.push_back(e);
        i_if_req = 1'b1; i_if_addr = a; w = 0;
        do begin @(negedge i_clk); w++; end while (!o_if_gnt && w < TMO);
        if (!o_if_gnt) begin
            checks++; errors++;
            $display("FAIL if_gnt_timeout: got no grant in %0d cycles, required grant", w);
            void'(if_q.pop_back());
        end
        i_if_req = 1'b0; i_if_addr = $urandom;
    endtask

    task automatic mem_access(input logic we, input logic [31:0] a, input logic [31:0] d, output int w);
        req_t e;
        e.is_mem = 1'b1; e.we = we; e.addr = a; e.wdata = d;
        mem_q.push_back(e);
        i_mem_req = 1'b1; i_mem_we = we; i_mem_addr = a; i_mem_wdata = d; w = 0;
        do begin @(negedge i_clk); w++; end while (!o_mem_gnt && w < TMO);
        if (!o_mem_gnt) begin
            checks++; errors++;
            $display("FAIL mem_gnt_timeout: got no grant in %0d cycles, required grant", w);
            void'(mem_q.pop_back());
        end
        i_mem_req = 1'b0; i_mem_we = $urandom; i_mem_addr = $urandom; i_mem_wdata = $urandom;
    endtask

    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({o_if_gnt, o_if_valid, o_mem_gnt, o_mem_valid,
                                 o_mux_sel, o_port_en, o_port_we, o_busy}), 64'(0));
        chk({tag, "_addr"}, 64'(o_port_addr), 64'(0));
        chk({tag, "_data"}, 64'(o_port_wdata | o_if_rdata | o_mem_rdata), 64'(0));
    endtask

    initial begin : stim
        int  w;
        logic exp_order [6];
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) exp_order[i] = !(GUARD && (i % 3 == 2));

        repeat (3) @(negedge i_clk);
        chk_zero("reset");
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);

        if_access(32'h40, w);
        chk("if_gnt_delay", 64'(w), 64'(1));
        repeat (MEM_LAT + 3) @(negedge i_clk);
        mem_access(1'b1, 32'h10, 32'hA5A5_A5A5, w);
        chk("mem_gnt_delay", 64'(w), 64'(1));
        repeat (MEM_LAT + 3) @(negedge i_clk);
        if_access(32'h10, w);
        repeat (MEM_LAT + 3) @(negedge i_clk);

        // Abandon an IF read mid-flight with an asynchronous reset.
        if_access(32'h20, w);
        @(negedge i_clk);
        #2 i_reset = 1'b1;
        #1 chk_zero("async_reset");
        cmp_q.delete();
        loss = 0;
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (6) @(negedge i_clk);
        if_access(32'h24, w);
        chk("post_reset_gnt_delay", 64'(w), 64'(1));
        repeat (MEM_LAT + 3) @(negedge i_clk);

        cont_mode = 1'b1;
        last_gnt  = -1;
        fork
            begin int wi; while (glog.size() < 6) if_access(raddr(), wi); end
            begin int wm; while (glog.size() < 6) mem_access($urandom_range(0, 1) == 1, raddr(), $urandom, wm); end
        join
        cont_mode = 1'b0;
        for (int i = 0; i < 6; i++) chk("grant_order", 64'(glog[i]), 64'(exp_order[i]));
        repeat (MEM_LAT + 3) @(negedge i_clk);

        repeat (20) begin
            @(negedge i_clk);
            chk("idle_port_en", 64'(o_port_en), 64'(0));
            chk("idle_busy", 64'(o_busy), 64'(0));
        end

        fork
            begin int wi; repeat (120) begin repeat ($urandom_range(0, 4)) @(negedge i_clk); if_access(raddr(), wi); end end
            begin int wm; repeat (120) begin repeat ($urandom_range(0, 4)) @(negedge i_clk);
                mem_access($urandom_range(0, 1) == 1, raddr(), $urandom, wm); end end
        join
        repeat (MEM_LAT + 4) @(negedge i_clk);
        chk("if_q_drained", 64'(if_q.size()), 64'(0));
        chk("mem_q_drained", 64'(mem_q.size()), 64'(0));
        chk("cmp_q_drained", 64'(cmp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
